sdram_pro_init: RTL and testbench

SDRAM_PRO_INIT -- requirements
Module: sdram_pro_init

---
 rtl/sdram_pro_init.sv | 121 ++++++++++++
 tb/tb_sdram_pro_init.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sdram_pro_init.sv
`default_nettype none
// ============================================================================
// Module  : sdram_pro_init
// Brief   : SDRAM power-up sequencer: wait, precharge-all, N auto-refreshes,
//           mode register load, then hold init_end until reset.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_pro_init #(
    parameter int          T_POWER  = 10000,
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          T_MRD    = 3,
    parameter int          AR_NUM   = 8,
    parameter logic [11:0] MODE_VAL = 12'h037
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_bank,
    output logic [11:0] init_addr,
    output logic        init_end
);

    localparam int C_CNT_W = ($clog2(T_POWER + 1) > 14) ? $clog2(T_POWER + 1) : 14;
    localparam int C_AR_W  = ($clog2(AR_NUM + 1) > 1) ? $clog2(AR_NUM + 1) : 1;

    localparam logic [3:0] c_CMD_NOP  = 4'b0111;
    localparam logic [3:0] c_CMD_PRE  = 4'b0010;
    localparam logic [3:0] c_CMD_AREF = 4'b0001;
    localparam logic [3:0] c_CMD_LMR  = 4'b0000;

    // Gray-style codes: adjacent states in the sequence differ by one bit
    localparam logic [2:0] c_INIT_WAIT = 3'b000;
    localparam logic [2:0] c_INIT_PRE  = 3'b001;
    localparam logic [2:0] c_INIT_TRP  = 3'b011;
    localparam logic [2:0] c_INIT_AR   = 3'b010;
    localparam logic [2:0] c_INIT_TRFC = 3'b110;
    localparam logic [2:0] c_INIT_MRS  = 3'b111;
    localparam logic [2:0] c_INIT_TMRD = 3'b101;
    localparam logic [2:0] c_INIT_END  = 3'b100;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W:0]   w_cnt_nxt;
    logic [C_CNT_W:0]   w_dwell;
    logic               w_last;
    logic [C_AR_W-1:0]  r_ar_cnt;

    // Dwell of the current state; one-cycle command states never consult it
    always_comb begin
        w_dwell = '0;
        case (r_state)
            c_INIT_WAIT: w_dwell = (C_CNT_W + 1)'(T_POWER);
            c_INIT_TRP:  w_dwell = (C_CNT_W + 1)'(T_RP);
            c_INIT_TRFC: w_dwell = (C_CNT_W + 1)'(T_RFC);
            c_INIT_TMRD: w_dwell = (C_CNT_W + 1)'(T_MRD);
            default:     w_dwell = '0;
        endcase
    end

    assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
    assign w_last    = (w_cnt_nxt >= w_dwell);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_INIT_WAIT: if (w_last) w_state_nxt = c_INIT_PRE;
            c_INIT_PRE:  w_state_nxt = c_INIT_TRP;
            c_INIT_TRP:  if (w_last) w_state_nxt = c_INIT_AR;
            c_INIT_AR:   w_state_nxt = c_INIT_TRFC;
            c_INIT_TRFC: begin
                if (w_last) begin
                    if (r_ar_cnt >= C_AR_W'(AR_NUM)) w_state_nxt = c_INIT_MRS;
                    else                             w_state_nxt = c_INIT_AR;
                end
            end
            c_INIT_MRS:  w_state_nxt = c_INIT_TMRD;
            c_INIT_TMRD: if (w_last) w_state_nxt = c_INIT_END;
            c_INIT_END:  w_state_nxt = c_INIT_END;
            default:     w_state_nxt = c_INIT_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= c_INIT_WAIT;
            r_cnt    <= '0;
            r_ar_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter restarts on every transition and freezes once done
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state != c_INIT_END)
                r_cnt <= w_cnt_nxt[C_CNT_W-1:0];
            if (r_state == c_INIT_AR)
                r_ar_cnt <= r_ar_cnt + 1'b1;
        end
    end

    always_comb begin
        init_cmd  = c_CMD_NOP;
        init_bank = 2'b11;
        init_addr = 12'hfff;
        init_end  = 1'b0;
        case (r_state)
            c_INIT_PRE: init_cmd = c_CMD_PRE;
            c_INIT_AR:  init_cmd = c_CMD_AREF;
            c_INIT_MRS: begin
                init_cmd  = c_CMD_LMR;
                init_bank = 2'b00;
                init_addr = MODE_VAL;
            end
            c_INIT_END: init_end = 1'b1;
            default:    init_cmd = c_CMD_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_pro_init.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_pro_init
// Brief   : Scoreboard bench for sdram_pro_init with default timing parameters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdram_pro_init;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [11:0] init_addr;
    logic        init_end;

    sdram_pro_init dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .init_cmd  (init_cmd),
        .init_bank (init_bank),
        .init_addr (init_addr),
        .init_end  (init_end)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [11:0] addr;
        logic        en;
        logic [2:0]  st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pre  = 0;
    int   n_ar   = 0;
    int   n_mrs  = 0;
    int   n_oth  = 0;

    // Hand-derived schedule for defaults; cycle -1 denotes reset values
    function automatic exp_t exp_of(input int c);
        exp_t e;
        int   k;
        e.cyc = c; e.cmd = 4'b0111; e.bank = 2'b11; e.addr = 12'hfff;
        e.en = 1'b0; e.st = 3'b000;
        if (c < 10000) begin
            e.st = 3'b000;
        end else if (c == 10000) begin
            e.st = 3'b001; e.cmd = 4'b0010;
        end else if (c <= 10002) begin
            e.st = 3'b011;
        end else if (c <= 10066) begin
            k = c - 10003;
            if (k % 8 == 0) begin
                e.st = 3'b010; e.cmd = 4'b0001;
            end else begin
                e.st = 3'b110;
            end
        end else if (c == 10067) begin
            e.st = 3'b111; e.cmd = 4'b0000; e.bank = 2'b00; e.addr = 12'h037;
        end else if (c <= 10070) begin
            e.st = 3'b101;
        end else begin
            e.st = 3'b100; e.en = 1'b1;
        end
        return e;
    endfunction

    task automatic do_cmp(input exp_t e);
        checks++;
        if (init_cmd !== e.cmd || init_bank !== e.bank || init_addr !== e.addr ||
            init_end !== e.en || dut.r_state !== e.st) begin
            errors++;
            $display("FAIL cyc%0d: got cmd=%b bank=%b addr=%h end=%b st=%b, expected cmd=%b bank=%b addr=%h end=%b st=%b",
                     e.cyc, init_cmd, init_bank, init_addr, init_end, dut.r_state,
                     e.cmd, e.bank, e.addr, e.en, e.st);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per presented output sample
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                do_cmp(e);
                case (init_cmd)
                    4'b0111: ;
                    4'b0010: n_pre++;
                    4'b0001: n_ar++;
                    4'b0000: begin
                        n_mrs++;
                        cmp_int("mrs_cas_latency", int'(init_addr[6:4]), 3);
                        cmp_int("mrs_burst_len", int'(init_addr[2:0]), 7);
                    end
                    default: n_oth++;
                endcase
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0;
        repeat (10) begin
            @(posedge sys_clk);
            q.push_back(exp_of(-1));
        end
        #10;
        sys_rst_n = 1'b1;

        // First run, interrupted during the 4th refresh recovery window
        for (int n = 1; n <= 10030; n++) begin
            @(posedge sys_clk);
            q.push_back(exp_of(n));
        end
        #5;
        sys_rst_n = 1'b0;
        #1;
        do_cmp(exp_of(-1));
        cmp_int("rst_cnt_clear", int'(dut.r_cnt), 0);
        cmp_int("run1_pre", n_pre, 1);
        cmp_int("run1_ar", n_ar, 4);
        cmp_int("run1_mrs", n_mrs, 0);
        n_pre = 0; n_ar = 0; n_mrs = 0;

        repeat (3) begin
            @(posedge sys_clk);
            q.push_back(exp_of(-1));
        end
        @(posedge sys_clk);
        #10;
        sys_rst_n = 1'b1;

        // Full second run plus >1000 cycles in the terminal state
        for (int n = 1; n <= 11100; n++) begin
            @(posedge sys_clk);
            q.push_back(exp_of(n));
        end
        @(posedge sys_clk);
        #2;
        cmp_int("run2_pre", n_pre, 1);
        cmp_int("run2_ar", n_ar, 8);
        cmp_int("run2_mrs", n_mrs, 1);
        cmp_int("other_cmds", n_oth, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
